// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: instruction fetch stage with a DEPTH-entry prefetch FIFO.
// Streams sequential 32-bit words from a synchronous ROM, tags each with its PC,
// and hands them to the decoder over a valid/ready handshake. A one-cycle
// redirect flushes the queue and the in-flight read, then refetches at a new PC.
// Optional feature: define PREFETCH_BYPASS_EN to forward a response straight to
// the outputs when the FIFO is empty, saving one cycle of latency.
module instr_prefetch_unit #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  output logic [ADDR_WIDTH-1:0]        instr_addr_out,
  input  logic [31:0]                  instr_in,
  input  logic [ADDR_WIDTH-1:0]        pc_in,
  input  logic                         set_pc_in,
  output logic [31:0]                  instr_out,
  output logic [ADDR_WIDTH-1:0]        instr_pc_out,
  output logic                         instr_valid_out,
  input  logic                         instr_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] tag_pc;
  logic                  inflight;

  logic [31:0]           mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic                  bypass_hit;
  logic                  pop;
  logic                  fifo_pop;
  logic                  push;
  logic                  issue;
  logic [CW:0]           occupancy;

  assign instr_addr_out = fetch_pc;
  assign count_out      = count;

  // Head selection, handshake and issue decision; bypass forwards the response when the FIFO is empty
  always_comb begin
`ifdef PREFETCH_BYPASS_EN
    bypass_hit = inflight && (count == '0);
`else
    bypass_hit = 1'b0;
`endif
    instr_valid_out = (count != '0) || bypass_hit;
    instr_out       = bypass_hit ? instr_in : mem_data[rd_ptr];
    instr_pc_out    = bypass_hit ? tag_pc   : mem_pc[rd_ptr];
    pop             = instr_valid_out && instr_ready_in;
    fifo_pop        = pop && (count != '0);
    push            = inflight && !set_pc_in && !(bypass_hit && instr_ready_in);
    occupancy       = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue           = !set_pc_in && (occupancy < (CW+1)'(DEPTH));
  end

  // Fetch PC, in-flight flag and tag of the outstanding ROM read
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
    end else if (set_pc_in) begin
      fetch_pc <= pc_in & ~ADDR_WIDTH'(3);
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      tag_pc   <= fetch_pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  // Prefetch FIFO storage, pointers and occupancy; a redirect empties it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (set_pc_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= instr_in;
        mem_pc[wr_ptr]   <= tag_pc;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The issue rule must never let a response land in a full FIFO
  no_overflow: assert property (@(posedge clk_in) disable iff (rst_in)
    !(push && !fifo_pop && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// tb_instr_prefetch_unit: directed bench for instr_prefetch_unit with a
// synchronous ROM model and a scoreboard of expected (pc, data) beats.
// Honours PREFETCH_BYPASS_EN for the expected first-valid latency.
module tb_instr_prefetch_unit;

  localparam int              AW     = 12;
  localparam int              DEPTH  = 4;
  localparam int              CW     = $clog2(DEPTH+1);
  localparam logic [AW-1:0]   RST_PC = '0;
`ifdef PREFETCH_BYPASS_EN
  localparam int              LAT    = 1;
`else
  localparam int              LAT    = 2;
`endif

  logic          clk         = 1'b0;
  logic          rst         = 1'b1;
  logic [AW-1:0] instr_addr;
  logic [31:0]   instr_in    = '0;
  logic [AW-1:0] pc_in       = '0;
  logic          set_pc      = 1'b0;
  logic [31:0]   instr_out;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [CW-1:0] count;

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   data;
  } beat_t;

  beat_t exp_q[$];

  int n_vec   = 0;
  int n_err   = 0;
  int n_beats = 0;
  int cyc     = 0;

  logic          s_valid;
  logic [AW-1:0] s_pc;
  logic [31:0]   s_data;
  logic [CW-1:0] s_count;
  logic [AW-1:0] s_addr;

  instr_prefetch_unit #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .instr_addr_out  (instr_addr),
    .instr_in        (instr_in),
    .pc_in           (pc_in),
    .set_pc_in       (set_pc),
    .instr_out       (instr_out),
    .instr_pc_out    (instr_pc),
    .instr_valid_out (instr_valid),
    .instr_ready_in  (instr_ready),
    .count_out       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return 32'hA000_0000 + 32'(a >> 2);
  endfunction

  // Synchronous ROM: data for the presented address appears one cycle later
  always @(posedge clk) instr_in <= rom_word(instr_addr);

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic sb_reset(input logic [AW-1:0] start);
    logic [AW-1:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{pc: p, data: rom_word(p)});
      p = p + AW'(4);
    end
  endtask

  // Sample the current cycle at the falling edge, score any accepted beat, then move into the next cycle
  task automatic run_cycle();
    beat_t e;
    @(negedge clk);
    s_valid = instr_valid;
    s_pc    = instr_pc;
    s_data  = instr_out;
    s_count = count;
    s_addr  = instr_addr;
    if (instr_valid && instr_ready) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("[TB] FAIL sb_extra observed pc=0x%03h expected no beat", instr_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 32'(instr_pc), 32'(e.pc));
        check("sb_data", instr_out, e.data);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic redirect(input logic [AW-1:0] target, input logic [AW-1:0] expected_start);
    set_pc      = 1'b1;
    pc_in       = target;
    instr_ready = 1'b0;
    sb_reset(expected_start);
    run_cycle();
    set_pc      = 1'b0;
    instr_ready = 1'b1;
  endtask

  initial begin
    int first_valid;
    int gaps;
    int beats0;
    logic [AW-1:0] wrap_pcs [2];
    int n_wrap;

    $display("[TB] start, LAT=%0d", LAT);

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr",  32'(instr_addr),  32'(RST_PC));
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_count", 32'(count),       32'd0);
    check("rst_data",  instr_out,        32'd0);
    check("rst_pc",    32'(instr_pc),    32'd0);

    // Startup stream with ready held high
    rst         = 1'b0;
    instr_ready = 1'b1;
    sb_reset(RST_PC);
    first_valid = -1;
    gaps        = 0;
    for (int c = 0; c < 8; c++) begin
      run_cycle();
      if (c == 0) check("addr_cycle0", 32'(s_addr), 32'(RST_PC));
      if (s_valid && first_valid < 0) first_valid = c;
      if (!s_valid && first_valid >= 0) gaps++;
    end
    check("first_valid_cycle", 32'(first_valid), 32'(LAT));
    check("stream_gaps",       32'(gaps),        32'd0);
    check("stream_beats",      32'(n_beats),     32'(8 - LAT));

    // Backpressure: restart at 0 with ready low, FIFO fills and fetching stops
    redirect(12'h000, 12'h000);
    instr_ready = 1'b0;
    for (int c = 0; c < 10; c++) run_cycle();
    check("bp_count", 32'(s_count), 32'(DEPTH));
    check("bp_addr",  32'(s_addr),  32'h010);
    beats0      = n_beats;
    instr_ready = 1'b1;
    for (int c = 0; c < 8; c++) run_cycle();
    check("bp_drain_beats", 32'(n_beats - beats0), 32'd8);
    check("pre_redirect_count", 32'(s_count), 32'd3);

    // Redirect with entries queued and a read in flight
    redirect(12'h100, 12'h100);
    for (int k = 1; k <= 4; k++) begin
      run_cycle();
      check("redir_valid", 32'(s_valid), 32'(k >= 1 + LAT));
      if (k == 1) check("redir_addr", 32'(s_addr), 32'h100);
      if (k == 1 + LAT) begin
        check("redir_head_pc",   32'(s_pc), 32'h100);
        check("redir_head_data", s_data,    rom_word(12'h100));
      end
    end
    for (int c = 0; c < 4; c++) run_cycle();

    // Misaligned redirect target has its low bits dropped
    redirect(12'h103, 12'h100);
    beats0 = n_beats;
    run_cycle();
    check("misaligned_addr", 32'(s_addr), 32'h100);
    for (int c = 0; c < 4; c++) run_cycle();
    check("misaligned_beats", 32'(n_beats - beats0), 32'(5 - LAT));

    // PC wrap at the top of the address space
    redirect(12'hFFC, 12'hFFC);
    n_wrap = 0;
    for (int c = 0; c < 6; c++) begin
      run_cycle();
      if (s_valid && n_wrap < 2) begin
        wrap_pcs[n_wrap] = s_pc;
        n_wrap++;
      end
    end
    check("wrap_beats", 32'(n_wrap), 32'd2);
    check("wrap_pc0",   32'(wrap_pcs[0]), 32'hFFC);
    check("wrap_pc1",   32'(wrap_pcs[1]), 32'h000);

    // Asynchronous reset between clock edges clears everything at once
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_count", 32'(count),       32'd0);
    check("async_data",  instr_out,        32'd0);
    check("async_pc",    32'(instr_pc),    32'd0);
    check("async_addr",  32'(instr_addr),  32'(RST_PC));
    run_cycle();
    run_cycle();
    rst = 1'b0;
    sb_reset(RST_PC);
    first_valid = -1;
    for (int c = 0; c < 6; c++) begin
      run_cycle();
      if (s_valid && first_valid < 0) first_valid = c;
    end
    check("restart_first_valid", 32'(first_valid), 32'(LAT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
# instr_prefetch_unit

Parametrised instruction fetch stage with a prefetch queue, sitting between the synchronous instruction ROM and the decoder. It streams sequential instruction words into a DEPTH-entry FIFO, each tagged with its PC, and hands them to the decoder over a valid/ready handshake. A single-cycle redirect flushes the queue and the in-flight ROM read, then restarts fetching at a new PC.

## Interface
- ADDR_WIDTH, 12: PC and ROM byte-address width; PC steps by 4.
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0: first fetch address after reset; word aligned.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- instr_addr_out  output  ADDR_WIDTH  ROM byte address; driven directly from the fetch PC register.
- instr_in  input  32  ROM read data; valid one cycle after the address was presented.
- pc_in  input  ADDR_WIDTH  redirect target; bits [1:0] ignored and forced to 0.
- set_pc_in  input  1  redirect strobe, one cycle.
- instr_out  output  32  FIFO head instruction.
- instr_pc_out  output  ADDR_WIDTH  PC of the FIFO head.
- instr_valid_out  output  1  FIFO head is valid.
- instr_ready_in  input  1  decoder accepts the head this cycle.
- count_out  output  $clog2(DEPTH+1)  occupied FIFO entries.

## Operation
- Reset values:
  - instr_addr_out = RESET_PC.
  - instr_valid_out, instr_out, instr_pc_out and count_out = 0.
  - In-flight flag = 0.
- Pop: a transfer happens when instr_valid_out && instr_ready_in. instr_valid_out is not gated by set_pc_in; a beat accepted in a redirect cycle counts as delivered.
- Issue condition: issue = !set_pc_in && (count + inflight - pop) < DEPTH.
- On issue:
  - fetch PC advances by 4, wrapping modulo 2^ADDR_WIDTH.
  - In-flight flag is set and the tag register takes the current fetch PC.
  - Without issue, fetch PC holds and the in-flight flag clears.
- Response: when the in-flight flag is set, instr_in and its tag are pushed into the FIFO at the end of that cycle.
- Full: the issue rule guarantees a push never meets a full FIFO. An overflow is a design error (assertion).
- Simultaneous push and pop: count is unchanged. Pop and push at DEPTH-1 entries is legal.
- Redirect (set_pc_in in cycle N):
  - At the edge, the FIFO is emptied, count becomes 0 and the in-flight flag is cleared. The data arriving in N+1 is discarded.
  - Fetch PC becomes {pc_in[ADDR_WIDTH-1:2],2'b00}.
  - Redirect overrides push, pop and issue in cycle N.
- While instr_valid_out = 0 after reset, instr_out and instr_pc_out hold their last values and are don't-care.
- Reset asserted mid-operation clears all state immediately, with no clock needed.

## Timing
- Cycle 0 is the first cycle with rst_in low. Fetch sequence after reset:
  - Cycle 0: instr_addr_out = RESET_PC, issue.
  - Cycle 1: data returns and is pushed.
  - Cycle 2: instr_valid_out = 1.
- Redirect in cycle N:
  - Cycle N+1: address = new PC.
  - Cycle N+2: data returns.
  - Cycle N+3: valid.
  - instr_valid_out = 0 in cycle N+1 and N+2.
- Throughput with instr_ready_in held at 1: one instruction per cycle, no bubbles, for any DEPTH >= 2.
- Backpressure: with ready low, the FIFO fills to DEPTH and issuing stops with zero entries in flight.

## Configuration
- PREFETCH_BYPASS_EN defined:
  - When the FIFO is empty and a response arrives, instr_in and its tag drive the outputs combinationally with instr_valid_out = 1 in the same cycle.
  - If that beat is accepted it is not pushed.
  - Reset and redirect latencies shrink by one cycle: first valid in cycle 1, redirect valid in N+2.
- PREFETCH_BYPASS_EN undefined: outputs come only from registered FIFO state, with the latencies given under Timing.

## Test plan
- Reset, RESET_PC=0, ROM word k = 0xA000_0000+k, ready=1: valid from cycle 2 (cycle 1 with bypass). Outputs pc 0x000,0x004,0x008 with data 0xA0000000,0xA0000001,0xA0000002, one per cycle, no gaps.
- DEPTH=4, ready held 0 for 10 cycles: count_out reaches 4 and instr_addr_out stops at 0x010. Raising ready then delivers pc 0x000..0x00C followed by 0x010, with no loss or duplication.
- With 3 entries queued and an in-flight read, pulse set_pc_in with pc_in=0x100: valid low in N+1 and N+2, head pc 0x100 in N+3. No old entry or the discarded in-flight data ever appears.
- RESET_PC=0xFFC, ADDR_WIDTH=12: delivered pcs are 0xFFC then 0x000.
- pc_in=0x103 with set_pc_in: fetch address and delivered pc are 0x100.
- Assert rst_in asynchronously mid-stream between edges: instr_valid_out, count_out and the outputs clear immediately, and instr_addr_out = RESET_PC before the next edge.
